// File: rtl/pacman_death_sequencer.sv
// Death sequencer: freezes play on Pac-Man's death, steps the death animation on frame ticks,
// then respawns or holds game-over until start. Optional READY hold via `DEATH_READY_HOLD_EN.
module pacman_death_sequencer #(
  parameter int unsigned FREEZE_FRAMES   = 60,
  parameter int unsigned ANIM_FRAMES     = 11,
  parameter int unsigned FRAMES_PER_STEP = 6,
  parameter int unsigned READY_FRAMES    = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       pacman_dead,
  input  logic       lives_nonzero,
  input  logic       start_btn,
  output logic       freeze,
  output logic       death_anim_en,
  output logic [3:0] death_frame,
  output logic       respawn,
  output logic       restart,
  output logic       game_over,
  output logic       ready_en,
  output logic [2:0] state
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FRAME_W = 4;

  typedef enum logic [2:0] {
    S_PLAY    = 3'd0,
    S_FREEZE  = 3'd1,
    S_ANIM    = 3'd2,
    S_RESPAWN = 3'd3,
    S_READY   = 3'd4,
    S_OVER    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               dead_q, start_q;
  logic               freeze_q, anim_en_q, respawn_q, restart_q, restart_d, game_over_q;
  logic               death_edge, start_edge;

  assign death_edge = pacman_dead & ~dead_q;
  assign start_edge = start_btn & ~start_q;

  // Next-state, counter and frame-index logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    restart_d = 1'b0;
    case (state_q)
      S_PLAY: begin
        if (death_edge) begin
          state_d = S_FREEZE;
          cnt_d   = CNT_W'(FREEZE_FRAMES - 1);
        end
      end
      S_FREEZE: begin
        if (frame_tick) begin
          if (cnt_q == '0) begin
            state_d = S_ANIM;
            frame_d = '0;
            cnt_d   = CNT_W'(FRAMES_PER_STEP - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_ANIM: begin
        if (frame_tick) begin
          if (cnt_q == '0) begin
            if (frame_q == FRAME_W'(ANIM_FRAMES - 1)) begin
              state_d = lives_nonzero ? S_RESPAWN : S_OVER;
            end else begin
              frame_d = frame_q + FRAME_W'(1);
              cnt_d   = CNT_W'(FRAMES_PER_STEP - 1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_RESPAWN: begin
`ifdef DEATH_READY_HOLD_EN
        state_d = S_READY;
        cnt_d   = CNT_W'(READY_FRAMES - 1);
`else
        state_d = S_PLAY;
`endif
      end
`ifdef DEATH_READY_HOLD_EN
      S_READY: begin
        if (frame_tick) begin
          if (cnt_q == '0) state_d = S_PLAY;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
`endif
      S_OVER: begin
        // restart pulses first; the move to RESPAWN follows one cycle later
        if (restart_q)       state_d   = S_RESPAWN;
        else if (start_edge) restart_d = 1'b1;
      end
      default: begin
        state_d = S_PLAY;
        cnt_d   = '0;
      end
    endcase
    if (state_d == S_RESPAWN) frame_d = '0;
  end

  // State, edge-detect and registered-output flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_PLAY;
      cnt_q       <= '0;
      frame_q     <= '0;
      dead_q      <= 1'b0;
      start_q     <= 1'b0;
      freeze_q    <= 1'b0;
      anim_en_q   <= 1'b0;
      respawn_q   <= 1'b0;
      restart_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      dead_q      <= pacman_dead;
      start_q     <= start_btn;
      freeze_q    <= (state_d != S_PLAY);
      anim_en_q   <= (state_d == S_ANIM);
      respawn_q   <= (state_d == S_RESPAWN);
      restart_q   <= restart_d;
      game_over_q <= (state_d == S_OVER);
    end
  end

`ifdef DEATH_READY_HOLD_EN
  logic ready_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_q <= 1'b0;
    else          ready_q <= (state_d == S_READY);
  end
  assign ready_en = ready_q;
`else
  assign ready_en = 1'b0;
`endif

  assign state         = state_q;
  assign freeze        = freeze_q;
  assign death_anim_en = anim_en_q;
  assign death_frame   = frame_q;
  assign respawn       = respawn_q;
  assign restart       = restart_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_pacman_death_sequencer.sv
// Directed bench for pacman_death_sequencer with FREEZE=2, ANIM=3, STEP=2, READY=2.
module tb_pacman_death_sequencer;

  logic       clk, reset_n, frame_tick, pacman_dead, lives_nonzero, start_btn;
  logic       freeze, death_anim_en, respawn, restart, game_over, ready_en;
  logic [3:0] death_frame;
  logic [2:0] state;

  int n_chk  = 0;
  int n_pass = 0;
  int resp_cnt = 0;
  int resp_base;

  pacman_death_sequencer #(
    .FREEZE_FRAMES(2), .ANIM_FRAMES(3), .FRAMES_PER_STEP(2), .READY_FRAMES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .pacman_dead(pacman_dead),
    .lives_nonzero(lives_nonzero), .start_btn(start_btn), .freeze(freeze),
    .death_anim_en(death_anim_en), .death_frame(death_frame), .respawn(respawn),
    .restart(restart), .game_over(game_over), .ready_en(ready_en), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (respawn) resp_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // one frame tick spanning exactly one clock edge
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; pacman_dead = 1'b0;
    lives_nonzero = 1'b1; start_btn = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_frame", 32'(death_frame), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_state", 32'(state), 32'd0);

    // reset asserted mid-animation
    pacman_dead = 1'b1;
    @(negedge clk);
    chk("s1_freeze", 32'(freeze), 32'd1);
    tick(); tick();
    chk("s1_anim", 32'(state), 32'd2);
    tick(); tick();
    chk("s1_frame1", 32'(death_frame), 32'd1);
    pacman_dead = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("s1_rst_state", 32'(state), 32'd0);
    chk("s1_rst_freeze", 32'(freeze), 32'd0);
    chk("s1_rst_anim", 32'(death_anim_en), 32'd0);
    chk("s1_rst_frame", 32'(death_frame), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("s1_post_state", 32'(state), 32'd0);
    chk("s1_post_freeze", 32'(freeze), 32'd0);

    // death with a life left, plus an ignored edge during ANIM and a held dead level
    resp_base = resp_cnt;
    pacman_dead = 1'b1;
    @(negedge clk);
    chk("s2_freeze", 32'(freeze), 32'd1);
    chk("s2_state_fr", 32'(state), 32'd1);
    chk("s2_anim_off", 32'(death_anim_en), 32'd0);
    tick();
    chk("s2_still_fr", 32'(state), 32'd1);
    tick();
    chk("s2_anim_on", 32'(death_anim_en), 32'd1);
    chk("s2_frame0", 32'(death_frame), 32'd0);
    tick();
    chk("s2_frame0b", 32'(death_frame), 32'd0);
    tick();
    chk("s2_frame1", 32'(death_frame), 32'd1);
    pacman_dead = 1'b0;
    @(negedge clk);
    pacman_dead = 1'b1;
    @(negedge clk);
    chk("s2_glitch_state", 32'(state), 32'd2);
    chk("s2_glitch_frame", 32'(death_frame), 32'd1);
    tick(); tick();
    chk("s2_frame2", 32'(death_frame), 32'd2);
    tick();
    chk("s2_last_wait", 32'(state), 32'd2);
    tick();
    chk("s2_respawn", 32'(respawn), 32'd1);
    chk("s2_resp_state", 32'(state), 32'd3);
    chk("s2_resp_frame", 32'(death_frame), 32'd0);
    chk("s2_resp_freeze", 32'(freeze), 32'd1);
    @(negedge clk);
    chk("s2_resp_width", 32'(respawn), 32'd0);
`ifdef DEATH_READY_HOLD_EN
    chk("s2_ready_state", 32'(state), 32'd4);
    chk("s2_ready_en", 32'(ready_en), 32'd1);
    chk("s2_ready_freeze", 32'(freeze), 32'd1);
    tick();
    chk("s2_ready_hold", 32'(ready_en), 32'd1);
    tick();
`endif
    chk("s2_play", 32'(state), 32'd0);
    chk("s2_play_freeze", 32'(freeze), 32'd0);
    chk("s2_ready_off", 32'(ready_en), 32'd0);
    repeat (4) @(negedge clk);
    chk("s2_no_retrig", 32'(state), 32'd0);
    chk("s2_resp_once", 32'(resp_cnt - resp_base), 32'd1);

    // last death with start held, then restart
    pacman_dead = 1'b0;
    @(negedge clk);
    resp_base = resp_cnt;
    start_btn = 1'b1;
    pacman_dead = 1'b1;
    @(negedge clk);
    chk("s3_state_fr", 32'(state), 32'd1);
    repeat (7) tick();
    chk("s3_pre_final", 32'(state), 32'd2);
    lives_nonzero = 1'b0;
    tick();
    chk("s3_over_state", 32'(state), 32'd5);
    chk("s3_game_over", 32'(game_over), 32'd1);
    chk("s3_over_freeze", 32'(freeze), 32'd1);
    chk("s3_over_anim", 32'(death_anim_en), 32'd0);
    chk("s3_over_frame", 32'(death_frame), 32'd2);
    repeat (3) @(negedge clk);
    chk("s6_held_start", 32'(restart), 32'd0);
    chk("s6_held_state", 32'(state), 32'd5);
    start_btn = 1'b0;
    @(negedge clk);
    chk("s6_released", 32'(restart), 32'd0);
    start_btn = 1'b1;
    @(negedge clk);
    chk("s4_restart", 32'(restart), 32'd1);
    chk("s4_no_resp_yet", 32'(respawn), 32'd0);
    chk("s3_never_resp", 32'(resp_cnt - resp_base), 32'd0);
    @(negedge clk);
    chk("s4_restart_width", 32'(restart), 32'd0);
    chk("s4_respawn", 32'(respawn), 32'd1);
    chk("s4_go_drop", 32'(game_over), 32'd0);
    chk("s4_resp_state", 32'(state), 32'd3);
    @(negedge clk);
    chk("s4_resp_width", 32'(respawn), 32'd0);
`ifdef DEATH_READY_HOLD_EN
    chk("s4_after", 32'(state), 32'd4);
`else
    chk("s4_after", 32'(state), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
